regfile_arbiter: RTL and testbench



---
 rtl/regfile_arbiter_if.sv | 43 ++++
 rtl/regfile_arbiter.sv | 83 ++++++++
 tb/tb_regfile_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Pipeline / register-file bus shared by regfile_arbiter: write and read request channels,
// read response channel and register-file pins. slave = arbiter side, master = environment side.
interface regfile_arbiter_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data1;
  logic [DW-1:0] rsp_data2;

  logic          rf_wr;
  logic [AW-1:0] rf_r1;
  logic [AW-1:0] rf_r2;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_out1;
  logic [DW-1:0] rf_out2;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr1, rd_addr2, rsp_ready,
           rf_out1, rf_out2,
    output wr_ready, rd_ready, rsp_valid, rsp_data1, rsp_data2,
           rf_wr, rf_r1, rf_r2, rf_rd, rf_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr1, rd_addr2, rsp_ready,
           rf_out1, rf_out2,
    input  wr_ready, rd_ready, rsp_valid, rsp_data1, rsp_data2,
           rf_wr, rf_r1, rf_r2, rf_rd, rf_wdata
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Write-priority arbiter for a 32x32 register file with bounded read starvation.
// Optional: REGFILE_ARB_ZERO_REG_EN makes r0 a hard-wired zero register.
module regfile_arbiter #(
  parameter int unsigned MAX_WR_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_arbiter_if.slave    bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WR_BURST);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             rsp_valid_q;
  logic             rsp_valid_nxt;
  logic             rd_eligible;
  logic             wr_grant;
  logic             rd_grant;

  // Grant decision and next-state
  always_comb begin
    rd_eligible    = bus.rd_valid && (!rsp_valid_q || bus.rsp_ready);
    wr_grant       = !rst && bus.wr_valid && !(rd_eligible && (starve_cnt == CNT_MAX));
    rd_grant       = !rst && !wr_grant && rd_eligible;
    starve_cnt_nxt = starve_cnt;
    rsp_valid_nxt  = rsp_valid_q;

    if (rd_grant || !rd_eligible) begin
      starve_cnt_nxt = '0;
    end else if (wr_grant && (starve_cnt < CNT_MAX)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end

    if (rd_grant) begin
      rsp_valid_nxt = 1'b1;
    end else if (bus.rsp_ready) begin
      rsp_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      starve_cnt  <= starve_cnt_nxt;
      rsp_valid_q <= rsp_valid_nxt;
    end
  end

  assign bus.wr_ready  = wr_grant;
  assign bus.rd_ready  = rd_grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rf_rd     = bus.wr_addr;
  assign bus.rf_wdata  = bus.wr_data;
  assign bus.rf_r1     = bus.rd_addr1;
  assign bus.rf_r2     = bus.rd_addr2;

`ifdef REGFILE_ARB_ZERO_REG_EN
  logic zero1_q;
  logic zero2_q;

  // Remember which read ports addressed r0 so the response can be forced to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero1_q <= 1'b0;
      zero2_q <= 1'b0;
    end else if (rd_grant) begin
      zero1_q <= (bus.rd_addr1 == '0);
      zero2_q <= (bus.rd_addr2 == '0);
    end
  end

  assign bus.rf_wr     = wr_grant && (bus.wr_addr != '0);
  assign bus.rsp_data1 = zero1_q ? '0 : bus.rf_out1;
  assign bus.rsp_data2 = zero2_q ? '0 : bus.rf_out2;
`else
  assign bus.rf_wr     = wr_grant;
  assign bus.rsp_data1 = bus.rf_out1;
  assign bus.rsp_data2 = bus.rf_out2;
`endif
endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard testbench for regfile_arbiter with a behavioural register file attached.
module tb_regfile_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_arbiter_if bus();

  regfile_arbiter #(.MAX_WR_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file: no reset, write blocks reads, outputs held on write cycles
  logic [31:0] regs [32];
  logic [31:0] out1 = 32'h0;
  logic [31:0] out2 = 32'h0;
  initial for (int i = 0; i < 32; i++) regs[i] = 32'h0;
  always @(posedge clk) begin
    if (bus.rf_wr) regs[bus.rf_rd] <= bus.rf_wdata;
    else begin
      out1 <= regs[bus.rf_r1];
      out2 <= regs[bus.rf_r2];
    end
  end
  assign bus.rf_out1 = out1;
  assign bus.rf_out2 = out2;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.d1 = d1;
    e.d2 = d2;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted response against the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got %h/%h expected none", bus.rsp_data1, bus.rsp_data2);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data1", bus.rsp_data1, e.d1);
        chk("rsp_data2", bus.rsp_data2, e.d2);
      end
    end
  end

  logic exp_rd;
  logic [31:0] zero_exp;

  initial begin
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 5'd9;
    bus.wr_data   = 32'h0BAD_0BAD;
    bus.rd_valid  = 1'b1;
    bus.rd_addr1  = 5'd0;
    bus.rd_addr2  = 5'd0;
    bus.rsp_ready = 1'b1;

    // Reset: no grants, no write, no response
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'h0);
    chk("rst_rd_ready", 32'(bus.rd_ready), 32'h0);
    chk("rst_rf_wr", 32'(bus.rf_wr), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    cyc();
    rst = 1'b0;

    // Write r5 then read r5/r0
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_wr_ready", 32'(bus.wr_ready), 32'h1);
    chk("t1_rf_wr", 32'(bus.rf_wr), 32'h1);
    chk("t1_rf_rd", 32'(bus.rf_rd), 32'd5);
    chk("t1_rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
    cyc();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd0;
    push(32'hDEADBEEF, 32'h0);
    @(negedge clk);
    chk("t1_rd_ready", 32'(bus.rd_ready), 32'h1);
    chk("t1_rf_r1", 32'(bus.rf_r1), 32'd5);
    cyc();
    bus.rd_valid = 1'b0;
    @(negedge clk);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    cyc();
    @(negedge clk);
    chk("t1_rsp_idle", 32'(bus.rsp_valid), 32'h0);

    // Same-cycle write and read of r7: write first, read returns new value
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h1234;
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd7; bus.rd_addr2 = 5'd5;
    push(32'h1234, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_wr_ready", 32'(bus.wr_ready), 32'h1);
    chk("t2_rd_ready0", 32'(bus.rd_ready), 32'h0);
    cyc();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("t2_rd_ready1", 32'(bus.rd_ready), 32'h1);
    cyc();
    bus.rd_valid = 1'b0;
    @(negedge clk);
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    cyc();

    // Continuous writes with a read pending: read wins in cycles 5 and 10
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd7;
    for (int i = 0; i < 10; i++) begin
      exp_rd = (i == 4) || (i == 9);
      bus.wr_valid = 1'b1; bus.wr_addr = 5'd20; bus.wr_data = 32'(i);
      if (exp_rd) push(32'hDEADBEEF, 32'h1234);
      @(negedge clk);
      chk($sformatf("t3_rd_ready[%0d]", i), 32'(bus.rd_ready), 32'(exp_rd));
      chk($sformatf("t3_wr_ready[%0d]", i), 32'(bus.wr_ready), 32'(!exp_rd));
      chk($sformatf("t3_rf_wr[%0d]", i), 32'(bus.rf_wr), 32'(!exp_rd));
      cyc();
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    cyc();

    // Response held under back-pressure while r3 keeps being written
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hA5A5A5A5;
    cyc();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd0;
    push(32'hA5A5A5A5, 32'h0);
    @(negedge clk);
    chk("t4_rd_ready", 32'(bus.rd_ready), 32'h1);
    bus.rsp_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 32'h100 + 32'(i);
      @(negedge clk);
      chk($sformatf("t4_hold_rd_ready[%0d]", i), 32'(bus.rd_ready), 32'h0);
      chk($sformatf("t4_hold_wr_ready[%0d]", i), 32'(bus.wr_ready), 32'h1);
      chk($sformatf("t4_hold_valid[%0d]", i), 32'(bus.rsp_valid), 32'h1);
      chk($sformatf("t4_hold_data1[%0d]", i), bus.rsp_data1, 32'hA5A5A5A5);
      cyc();
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    cyc();
    cyc();

    // Write to r0, then read it back
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("t5_wr_ready", 32'(bus.wr_ready), 32'h1);
`ifdef REGFILE_ARB_ZERO_REG_EN
    chk("t5_rf_wr", 32'(bus.rf_wr), 32'h0);
    zero_exp = 32'h0;
`else
    chk("t5_rf_wr", 32'(bus.rf_wr), 32'h1);
    zero_exp = 32'hFFFFFFFF;
`endif
    cyc();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd0;
    push(zero_exp, zero_exp);
    cyc();
    bus.rd_valid = 1'b0;
    cyc();
    cyc();

    // Reset while a response waits: dropped asynchronously, r5 preserved
    bus.rsp_ready = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd7;
    cyc();
    bus.rd_valid = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid_pre", 32'(bus.rsp_valid), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rsp_valid_async", 32'(bus.rsp_valid), 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd7;
    push(32'hDEADBEEF, 32'h1234);
    cyc();
    bus.rd_valid = 1'b0;
    repeat (4) cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
